// File: rtl/bnn_seq_ctrl.sv
// Top-level sequencer for the MNIST BNN. Drives the shared stage bus through
// IDLE -> LOAD -> L1 -> L2 -> L3 -> DONE on per-stage done handshakes, latches the
// classified digit, and aborts to IDLE with a sticky error if any stage stalls.
module bnn_seq_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 1023,
  parameter int unsigned CNT_W       = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             load_done,
  input  logic             l1_done,
  input  logic             l2_done,
  input  logic             l3_done,
  input  logic [3:0]       l3_class,
  output logic [2:0]       state,
  output logic             stage_start,
  output logic             busy,
  output logic [3:0]       digit,
  output logic             digit_valid,
  output logic             err_timeout
);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StLoad = 3'd1,
    StL1   = 3'd2,
    StL2   = 3'd3,
    StL3   = 3'd4,
    StDone = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT_CYC);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             stage_start_q, stage_start_d;
  logic             busy_q, busy_d;
  logic [3:0]       digit_q, digit_d;
  logic             digit_valid_q, digit_valid_d;
  logic             err_q, err_d;
  logic             in_stage;
  logic             timeout;

  // Watchdog: saturating count; abort when this edge would bring the count to the limit,
  // so a stage may occupy at most TIMEOUT_CYC cycles.
  always_comb begin
    in_stage = (state_q == StLoad) || (state_q == StL1) ||
               (state_q == StL2)   || (state_q == StL3);
    cnt_inc  = (cnt_q == TimeoutVal) ? cnt_q : cnt_q + CNT_W'(1);
    timeout  = in_stage && (cnt_inc == TimeoutVal);
  end

  // Next-state and registered-output decode; a matching done always beats the watchdog.
  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          err_d   = 1'b0;
        end
      end
      StLoad: begin
        if (load_done) begin
          state_d = StL1;
        end else if (timeout) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end
      end
      StL1: begin
        if (l1_done) begin
          state_d = StL2;
        end else if (timeout) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end
      end
      StL2: begin
        if (l2_done) begin
          state_d = StL3;
        end else if (timeout) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end
      end
      StL3: begin
        if (l3_done) begin
          state_d = StDone;
          digit_d = l3_class;
        end else if (timeout) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end
      end
      StDone: begin
        // Require start to drop before another run can begin.
        if (!start) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    cnt_d         = ((state_d != state_q) || !in_stage) ? '0 : cnt_inc;
    stage_start_d = (state_d != state_q) &&
                    ((state_d == StL1) || (state_d == StL2) || (state_d == StL3));
    busy_d        = (state_d == StLoad) || (state_d == StL1) ||
                    (state_d == StL2)   || (state_d == StL3);
    digit_valid_d = (state_d == StDone);
  end

  // State, watchdog and all outputs registered together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      stage_start_q <= 1'b0;
      busy_q        <= 1'b0;
      digit_q       <= 4'd0;
      digit_valid_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stage_start_q <= stage_start_d;
      busy_q        <= busy_d;
      digit_q       <= digit_d;
      digit_valid_q <= digit_valid_d;
      err_q         <= err_d;
    end
  end

  assign state       = state_q;
  assign stage_start = stage_start_q;
  assign busy        = busy_q;
  assign digit       = digit_q;
  assign digit_valid = digit_valid_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_bnn_seq_ctrl.sv
// Bench for bnn_seq_ctrl: stimulus pushes the expected stage transitions (with the
// dwell of the stage being left) into a queue; a monitor pops one per observed change.
module tb_bnn_seq_ctrl;

  localparam int unsigned Timeout = 1023;

  logic       clk;
  logic       reset_n;
  logic       start, load_done, l1_done, l2_done, l3_done;
  logic [3:0] l3_class;
  logic [2:0] state;
  logic       stage_start, busy, digit_valid, err_timeout;
  logic [3:0] digit;

  typedef struct {
    logic [2:0] st;
    int         dwell;
    logic [3:0] digit;
    logic       dv;
    logic       err;
    logic       busy;
    logic       ss;
  } exp_t;

  exp_t       q[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         exp_ss = 0;
  int         ss_seen = 0;
  logic [3:0] model_digit = 4'd0;

  bnn_seq_ctrl #(
    .TIMEOUT_CYC(Timeout),
    .CNT_W      (10)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .load_done  (load_done),
    .l1_done    (l1_done),
    .l2_done    (l2_done),
    .l3_done    (l3_done),
    .l3_class   (l3_class),
    .state      (state),
    .stage_start(stage_start),
    .busy       (busy),
    .digit      (digit),
    .digit_valid(digit_valid),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [2:0] st, input int dw, input logic err);
    exp_t e;
    e.st    = st;
    e.dwell = dw;
    e.digit = model_digit;
    e.dv    = (st == 3'd5);
    e.err   = err;
    e.busy  = (st >= 3'd1) && (st <= 3'd4);
    e.ss    = (st >= 3'd2) && (st <= 3'd4);
    if (e.ss) exp_ss++;
    q.push_back(e);
  endtask

  // Wait k falling edges, then drive exactly one handshake (0 start, 1 load, 2-4 layers).
  task automatic step(input int k, input int idx);
    repeat (k) @(negedge clk);
    start   = 1'b0;
    l1_done = 1'b0;
    l2_done = 1'b0;
    l3_done = 1'b0;
    case (idx)
      0: start     = 1'b1;
      1: load_done = 1'b1;
      2: l1_done   = 1'b1;
      3: l2_done   = 1'b1;
      4: l3_done   = 1'b1;
      default: ;
    endcase
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, int'(state), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_digit"}, int'(digit), 0);
    chk({tag, "_digit_valid"}, int'(digit_valid), 0);
    chk({tag, "_err"}, int'(err_timeout), 0);
    chk({tag, "_stage_start"}, int'(stage_start), 0);
  endtask

  // Monitor: one queue entry per observed state change.
  initial begin
    logic [2:0] prev_st;
    int         dwell;
    int         n_tr;
    exp_t       e;
    prev_st = 3'd0;
    dwell   = 0;
    n_tr    = 0;
    forever begin
      @(posedge clk);
      #1;
      if (stage_start) ss_seen++;
      if (state !== prev_st) begin
        n_tr++;
        if (q.size() == 0) begin
          chk($sformatf("tr%0d_unexpected_state", n_tr), int'(state), int'(prev_st));
        end else begin
          e = q.pop_front();
          chk($sformatf("tr%0d_state", n_tr), int'(state), int'(e.st));
          if (e.dwell >= 0) chk($sformatf("tr%0d_dwell", n_tr), dwell, e.dwell);
          chk($sformatf("tr%0d_digit", n_tr), int'(digit), int'(e.digit));
          chk($sformatf("tr%0d_digit_valid", n_tr), int'(digit_valid), int'(e.dv));
          chk($sformatf("tr%0d_err", n_tr), int'(err_timeout), int'(e.err));
          chk($sformatf("tr%0d_busy", n_tr), int'(busy), int'(e.busy));
          chk($sformatf("tr%0d_stage_start", n_tr), int'(stage_start), int'(e.ss));
        end
        prev_st = state;
        dwell   = 1;
      end else begin
        dwell++;
      end
    end
  end

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    load_done = 1'b0;
    l1_done   = 1'b0;
    l2_done   = 1'b0;
    l3_done   = 1'b0;
    l3_class  = 4'd0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset_n = 1'b1;

    // Full inference, digit 7.
    step(2, 0);   push(3'd1, -1, 1'b0);
    step(784, 1); push(3'd2, 784, 1'b0);
    step(5, 2);   push(3'd3, 5, 1'b0);
    step(5, 3);   push(3'd4, 5, 1'b0);
    l3_class = 4'd7;
    step(5, 4);   model_digit = 4'd7; push(3'd5, 5, 1'b0); push(3'd0, 1, 1'b0);
    step(3, 5);

    // load_done still high: one LOAD cycle; then L2 stalls into the watchdog.
    step(2, 0);   push(3'd1, -1, 1'b0); push(3'd2, 1, 1'b0);
    step(6, 2);   push(3'd3, 5, 1'b0); push(3'd0, Timeout, 1'b1);
    step(Timeout + 5, 5);

    // Restart clears the error; stray l3_done in L1 ignored; done on the timeout cycle wins.
    step(2, 0);   push(3'd1, -1, 1'b0); push(3'd2, 1, 1'b0);
    l3_class = 4'd3;
    step(2, 4);
    step(3, 2);   push(3'd3, 4, 1'b0);
    step(Timeout, 3); push(3'd4, Timeout, 1'b0);
    l3_class = 4'd12;
    step(5, 4);   model_digit = 4'd12; push(3'd5, 5, 1'b0);
    start = 1'b1; push(3'd0, 20, 1'b0);
    step(20, 5);

    // Asynchronous reset in the middle of L2.
    step(2, 0);   push(3'd1, -1, 1'b0); push(3'd2, 1, 1'b0);
    step(6, 2);   push(3'd3, 5, 1'b0);
    repeat (3) @(negedge clk);
    model_digit = 4'd0;
    push(3'd0, -1, 1'b0);
    #2 reset_n = 1'b0;
    #1 chk_all_zero("async_reset");
    @(negedge clk);
    load_done = 1'b0;
    l1_done   = 1'b0;
    reset_n   = 1'b1;

    // Short stages back to back.
    step(2, 0);   push(3'd1, -1, 1'b0);
    step(10, 1);  push(3'd2, 10, 1'b0);
    step(1, 2);   push(3'd3, 1, 1'b0);
    step(1, 3);   push(3'd4, 1, 1'b0);
    l3_class = 4'd9;
    step(1, 4);   model_digit = 4'd9; push(3'd5, 1, 1'b0); push(3'd0, 1, 1'b0);
    step(10, 5);

    chk("queue_empty", q.size(), 0);
    chk("stage_start_count", ss_seen, exp_ss);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
